mxrv_trap_ctrl: RTL

- Sequences the machine-mode CSR file on trap entry and on mret for the single-issue RV32 core.
- Arbitrates the CSR file's single write port between the execute stage (CSR instructions) and its own trap/mret write sequence.
- Holds the pipeline for the whole sequence, then issues a redirect to the trap vector or to mepc.

---
 rtl/mxrv_trap_pkg.sv | 56 +++++
 rtl/mxrv_trap_prio.sv | 49 ++++
 rtl/mxrv_trap_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mxrv_trap_pkg.sv
// Shared constants, state encoding and mstatus update helpers for the trap controller.
package mxrv_trap_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int CSR_AW_DEF = 12;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL     = 32'd11;
    localparam logic [31:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
    localparam logic [31:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;
    localparam int MIE_MEIE       = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MCAUSE,
        ST_W_MTVAL,
        ST_W_MSTATUS,
        ST_JUMP,
        ST_R_MSTATUS,
        ST_R_JUMP
    } trap_state_e;

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] snap);
        logic [31:0] s;
        s = snap;
        s[MSTATUS_MPIE] = snap[MSTATUS_MIE];
        s[MSTATUS_MIE]  = 1'b0;
        s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return s;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] snap);
        logic [31:0] s;
        s = snap;
        s[MSTATUS_MIE]  = snap[MSTATUS_MPIE];
        s[MSTATUS_MPIE] = 1'b1;
        s[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return s;
    endfunction

endpackage

// File: rtl/mxrv_trap_prio.sv
// Priority encoder: picks the winning trap source and produces its cause and mtval.
module mxrv_trap_prio
    import mxrv_trap_pkg::*;
(
    input  logic        exc_ecall,
    input  logic        exc_ebreak,
    input  logic        exc_illegal,
    input  logic        mret,
    input  logic        irq_timer,
    input  logic        irq_ext,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic [31:0] inst,
    output logic        trap_req,
    output logic        mret_req,
    output logic [31:0] cause,
    output logic [31:0] mtval
);

    logic ext_en;
    logic timer_en;

    assign ext_en   = mstatus_mie & irq_ext & mie_meie;
    assign timer_en = mstatus_mie & irq_timer & mie_mtie;

    always_comb begin
        trap_req = 1'b1;
        mret_req = 1'b0;
        cause    = '0;
        mtval    = '0;
        if (exc_illegal) begin
            cause = CAUSE_ILLEGAL;
            mtval = inst;
        end else if (exc_ebreak) begin
            cause = CAUSE_EBREAK;
        end else if (exc_ecall) begin
            cause = CAUSE_ECALL;
        end else if (ext_en) begin
            cause = CAUSE_IRQ_EXT;
        end else if (timer_en) begin
            cause = CAUSE_IRQ_TIMER;
        end else begin
            trap_req = 1'b0;
            mret_req = mret;
        end
    end

endmodule

// File: rtl/mxrv_trap_ctrl.sv
// Trap/mret CSR write sequencer and CSR write-port arbiter.
// MXRV_TRAP_VECTORED_EN enables vectored interrupt targets when mtvec mode is 01.
//   state        | meaning
//   ST_IDLE      | ex port passes through; accept trap or mret
//   ST_W_MEPC    | write mepc from pc snapshot
//   ST_W_MCAUSE  | write mcause
//   ST_W_MTVAL   | write mtval
//   ST_W_MSTATUS | write trap-entry mstatus
//   ST_JUMP      | redirect to trap vector
//   ST_R_MSTATUS | write mret mstatus
//   ST_R_JUMP    | redirect to mepc
module mxrv_trap_ctrl
    import mxrv_trap_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exc_ecall_i,
    input  logic              exc_ebreak_i,
    input  logic              exc_illegal_i,
    input  logic              mret_i,
    input  logic              irq_timer_i,
    input  logic              irq_ext_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    input  logic              ex_we_i,
    input  logic [CSR_AW-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    input  logic [XLEN-1:0]   mstatus_i,
    input  logic [XLEN-1:0]   mie_i,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic              hold_o,
    output logic              jump_o,
    output logic [XLEN-1:0]   jump_addr_o
);

    trap_state_e     state, state_nxt;
    logic            trap_req, mret_req;
    logic [31:0]     cause_sel, mtval_sel;
    logic [XLEN-1:0] pc_q, cause_q, mtval_q, mstatus_q;
    logic [XLEN-1:0] vec_off;
    logic            unused_bits;

    mxrv_trap_prio u_prio (
        .exc_ecall   (exc_ecall_i),
        .exc_ebreak  (exc_ebreak_i),
        .exc_illegal (exc_illegal_i),
        .mret        (mret_i),
        .irq_timer   (irq_timer_i),
        .irq_ext     (irq_ext_i),
        .mstatus_mie (mstatus_i[MSTATUS_MIE]),
        .mie_mtie    (mie_i[MIE_MTIE]),
        .mie_meie    (mie_i[MIE_MEIE]),
        .inst        (inst_i),
        .trap_req    (trap_req),
        .mret_req    (mret_req),
        .cause       (cause_sel),
        .mtval       (mtval_sel)
    );

`ifdef MXRV_TRAP_VECTORED_EN
    assign vec_off = (mtvec_i[1:0] == 2'b01 && cause_q[XLEN-1]) ?
                     {cause_q[XLEN-3:0], 2'b00} : '0;
    assign unused_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:0], cause_q[XLEN-2]};
`else
    assign vec_off = '0;
    assign unused_bits = ^{mie_i[XLEN-1:12], mie_i[10:8], mie_i[6:0], mtvec_i[1:0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Snapshots are taken only in the acceptance cycle so live CSR changes cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= '0;
            cause_q   <= '0;
            mtval_q   <= '0;
            mstatus_q <= '0;
        end else if (state == ST_IDLE) begin
            if (trap_req) begin
                pc_q      <= pc_i;
                cause_q   <= cause_sel;
                mtval_q   <= mtval_sel;
                mstatus_q <= mstatus_i;
            end else if (mret_req) begin
                mstatus_q <= mstatus_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (trap_req)      state_nxt = ST_W_MEPC;
                else if (mret_req) state_nxt = ST_R_MSTATUS;
            end
            ST_W_MEPC:    state_nxt = ST_W_MCAUSE;
            ST_W_MCAUSE:  state_nxt = ST_W_MTVAL;
            ST_W_MTVAL:   state_nxt = ST_W_MSTATUS;
            ST_W_MSTATUS: state_nxt = ST_JUMP;
            ST_JUMP:      state_nxt = ST_IDLE;
            ST_R_MSTATUS: state_nxt = ST_R_JUMP;
            ST_R_JUMP:    state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted, including the IDLE pass-through.
    always_comb begin
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        hold_o      = 1'b0;
        jump_o      = 1'b0;
        jump_addr_o = '0;
        if (rst_n) begin
            case (state)
                ST_IDLE: begin
                    if (trap_req || mret_req) begin
                        hold_o = 1'b1;
                    end else if (ex_we_i) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = ex_waddr_i;
                        csr_wdata_o = ex_wdata_i;
                    end
                end
                ST_W_MEPC: begin
                    hold_o = 1'b1; csr_we_o = 1'b1;
                    csr_waddr_o = CSR_AW'(CSR_MEPC);
                    csr_wdata_o = pc_q;
                end
                ST_W_MCAUSE: begin
                    hold_o = 1'b1; csr_we_o = 1'b1;
                    csr_waddr_o = CSR_AW'(CSR_MCAUSE);
                    csr_wdata_o = cause_q;
                end
                ST_W_MTVAL: begin
                    hold_o = 1'b1; csr_we_o = 1'b1;
                    csr_waddr_o = CSR_AW'(CSR_MTVAL);
                    csr_wdata_o = mtval_q;
                end
                ST_W_MSTATUS: begin
                    hold_o = 1'b1; csr_we_o = 1'b1;
                    csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                    csr_wdata_o = mstatus_on_trap(mstatus_q);
                end
                ST_JUMP: begin
                    hold_o = 1'b1; jump_o = 1'b1;
                    jump_addr_o = {mtvec_i[XLEN-1:2], 2'b00} + vec_off;
                end
                ST_R_MSTATUS: begin
                    hold_o = 1'b1; csr_we_o = 1'b1;
                    csr_waddr_o = CSR_AW'(CSR_MSTATUS);
                    csr_wdata_o = mstatus_on_mret(mstatus_q);
                end
                ST_R_JUMP: begin
                    hold_o = 1'b1; jump_o = 1'b1;
                    jump_addr_o = mepc_i;
                end
                default: ;
            endcase
        end
    end

endmodule
